regfile_sb: RTL and testbench

- Parametrised general-purpose register file that replaces the fixed 32x32, 2-read/1-write register file.
- Adds configurable width, depth and read-port count, a write-to-read bypass, and a per-register scoreboard (busy bits).
- The scoreboard lets the decode stage detect RAW hazards on writes still in flight.
- Sits between decode (reads, issue) and writeback (write, busy clear).

---
 rtl/regfile_pkg.sv | 31 +++
 rtl/regfile_scoreboard.sv | 60 ++++++
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package regfile_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

    // Helpers work on a fixed maximum width; callers zero-extend / truncate.
    localparam int MAX_NREG = 1024;
    localparam int MAX_AW   = 10;

    // Number of set bits in a vector of up to MAX_NREG entries.
    function automatic int unsigned popcount(input logic [MAX_NREG-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_NREG; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // Register address to one-hot select vector.
    function automatic logic [MAX_NREG-1:0] addr_onehot(input logic [MAX_AW-1:0] a);
        logic [MAX_NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits (pending writes) with set/clear priority and a busy count.
// Latency: busy and busy_cnt update one cycle after issue/writeback/flush.
// Backpressure: none; every issue, writeback and flush is accepted each cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG     = DEF_NREG,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     busy_cnt
);

    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     busy_cnt_nxt;

    // Next busy vector: flush beats issue, issue beats a same-register writeback clear.
    always_comb begin
        set_vec  = '0;
        clr_vec  = '0;
        busy_nxt = busy;
        if (iss_valid) begin
            set_vec = NREG'(addr_onehot(MAX_AW'(iss_rd)));
        end
        if (wen) begin
            clr_vec = NREG'(addr_onehot(MAX_AW'(waddr)));
        end
        if (flush) begin
            busy_nxt = '0;
        end else begin
            busy_nxt = (busy & ~clr_vec) | set_vec;
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
        busy_cnt_nxt = (AW+1)'(popcount(MAX_NREG'(busy_nxt)));
    end

    // Busy bits and their count are registered together so the count always matches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with NRD combinational read ports, optional write bypass and scoreboard.
// Latency: reads are zero-latency; writes and busy updates take effect at the next rising edge.
// Backpressure: none; reads, write, issue and flush are all accepted every cycle.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN     = DEF_XLEN,
    parameter  int NREG     = DEF_NREG,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                wen,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;
    logic            wr_ok;

    // Writes to the hardwired zero register are silently dropped.
    assign wr_ok = wen && !((ZERO_REG != 0) && (waddr == '0));

    // Data array: cleared on reset, one write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    regfile_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wen       (wen),
        .waddr     (waddr),
        .flush     (flush),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit_zero;
        logic            hit_byp;
        logic [XLEN-1:0] rd_dat;
        logic            rd_busy;

        assign ra       = raddr[k*AW +: AW];
        assign hit_zero = (ZERO_REG != 0) && (ra == '0);
        // A same-cycle writeback to the addressed register both supplies the data
        // and retires the pending write, so the reader sees it as ready.
        assign hit_byp  = (BYPASS != 0) && wen && (waddr == ra) && !hit_zero;

        // Read mux: hardwired zero, then bypass, then stored value.
        always_comb begin
            rd_dat  = mem[ra];
            rd_busy = busy[ra];
            if (hit_zero) begin
                rd_dat  = '0;
                rd_busy = 1'b0;
            end else if (hit_byp) begin
                rd_dat  = wdata;
                rd_busy = 1'b0;
            end
        end

        assign rdata[k*XLEN +: XLEN] = rd_dat;
        assign rbusy[k]              = rd_busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb in three configurations.
// Latency: checks combinational reads in-cycle and registered state one edge later.
// Backpressure: not applicable.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;

    // Shared stimulus for the default (a) and BYPASS=0/ZERO_REG=0 (b) instances.
    logic [9:0]  raddr;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rbusy_a, rbusy_b;
    logic [5:0]  busy_cnt_a, busy_cnt_b;

    // NREG=16, NRD=3 instance (c).
    logic [11:0] raddr_c;
    logic        wen_c;
    logic [3:0]  waddr_c;
    logic        iss_valid_c;
    logic [3:0]  iss_rd_c;
    logic        flush_c;
    logic [95:0] rdata_c;
    logic [2:0]  rbusy_c;
    logic [4:0]  busy_cnt_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_sb dut_a (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .flush(flush), .busy_cnt(busy_cnt_a)
    );

    regfile_sb #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .flush(flush), .busy_cnt(busy_cnt_b)
    );

    regfile_sb #(.NREG(16), .NRD(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .raddr(raddr_c), .rdata(rdata_c), .rbusy(rbusy_c),
        .wen(wen_c), .waddr(waddr_c), .wdata(wdata), .iss_valid(iss_valid_c), .iss_rd(iss_rd_c),
        .flush(flush_c), .busy_cnt(busy_cnt_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
        raddr_c = '0; wen_c = 1'b0; waddr_c = '0;
        iss_valid_c = 1'b0; iss_rd_c = '0; flush_c = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (busy_cnt_a !== 6'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", busy_cnt_a); end
        n_cmp++; if (rbusy_a !== 2'b00) begin n_err++; $display("FAIL reset_rbusy: got %b expected 00", rbusy_a); end
        n_cmp++; if (rdata_b !== 64'd0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", rdata_b); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Write and issue reg5 in the same cycle, then reset mid-run.
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        idle(); raddr = {5'd0, 5'd5};
        #1;
        n_cmp++; if (rdata_a[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL pre_reset_rd5: got %h expected deadbeef", rdata_a[31:0]); end
        n_cmp++; if (rbusy_a[0] !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy5: got %b expected 1", rbusy_a[0]); end
        n_cmp++; if (busy_cnt_a !== 6'd1) begin n_err++; $display("FAIL pre_reset_cnt: got %0d expected 1", busy_cnt_a); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rdata_a[31:0] !== 32'd0) begin n_err++; $display("FAIL midreset_rd5: got %h expected 0", rdata_a[31:0]); end
        n_cmp++; if (rbusy_a[0] !== 1'b0) begin n_err++; $display("FAIL midreset_busy5: got %b expected 0", rbusy_a[0]); end
        n_cmp++; if (busy_cnt_a !== 6'd0) begin n_err++; $display("FAIL midreset_cnt: got %0d expected 0", busy_cnt_a); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_write_bypass();
        idle();
        wen = 1'b1; waddr = 5'd3; wdata = 32'h12345678;
        tick();
        wen = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        tick();
        idle(); raddr = {5'd0, 5'd3};
        #1;
        n_cmp++; if (rdata_a[31:0] !== 32'h12345678) begin n_err++; $display("FAIL write_rd3: got %h expected 12345678", rdata_a[31:0]); end
        // Same-cycle write of reg7 while port1 reads it.
        wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr = {5'd7, 5'd3};
        #1;
        n_cmp++; if (rdata_a[63:32] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bypass_p1: got %h expected a5a5a5a5", rdata_a[63:32]); end
        n_cmp++; if (rdata_b[63:32] !== 32'h11111111) begin n_err++; $display("FAIL nobypass_p1: got %h expected 11111111", rdata_b[63:32]); end
        n_cmp++; if (rdata_a[31:0] !== 32'h12345678) begin n_err++; $display("FAIL bypass_p0_indep: got %h expected 12345678", rdata_a[31:0]); end
        tick();
        wen = 1'b0;
        #1;
        n_cmp++; if (rdata_b[63:32] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL nobypass_after: got %h expected a5a5a5a5", rdata_b[63:32]); end
    endtask

    task automatic test_zero_reg();
        idle();
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; iss_valid = 1'b1; iss_rd = 5'd0;
        raddr = 10'd0;
        #1;
        n_cmp++; if (rdata_a[31:0] !== 32'd0) begin n_err++; $display("FAIL zero_inflight_rd: got %h expected 0", rdata_a[31:0]); end
        n_cmp++; if (rdata_b[31:0] !== 32'd0) begin n_err++; $display("FAIL nozero_inflight_rd: got %h expected 0", rdata_b[31:0]); end
        tick();
        idle();
        #1;
        n_cmp++; if (rdata_a[31:0] !== 32'd0) begin n_err++; $display("FAIL zero_rd: got %h expected 0", rdata_a[31:0]); end
        n_cmp++; if (rbusy_a !== 2'b00) begin n_err++; $display("FAIL zero_rbusy: got %b expected 00", rbusy_a); end
        n_cmp++; if (busy_cnt_a !== 6'd0) begin n_err++; $display("FAIL zero_cnt: got %0d expected 0", busy_cnt_a); end
        n_cmp++; if (rdata_b[31:0] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL nozero_rd: got %h expected ffffffff", rdata_b[31:0]); end
        n_cmp++; if (busy_cnt_b !== 6'd1) begin n_err++; $display("FAIL nozero_cnt: got %0d expected 1", busy_cnt_b); end
        // Retire the pending reg0 write in the ordinary-reg0 instance.
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        tick();
        idle();
        #1;
        n_cmp++; if (busy_cnt_b !== 6'd0) begin n_err++; $display("FAIL nozero_retire_cnt: got %0d expected 0", busy_cnt_b); end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd10;
        tick();
        idle(); raddr = {5'd0, 5'd10};
        #1;
        n_cmp++; if (rbusy_a[0] !== 1'b1) begin n_err++; $display("FAIL sb_busy10: got %b expected 1", rbusy_a[0]); end
        n_cmp++; if (busy_cnt_a !== 6'd1) begin n_err++; $display("FAIL sb_cnt1: got %0d expected 1", busy_cnt_a); end
        wen = 1'b1; waddr = 5'd10; wdata = 32'hCAFE0010;
        #1;
        n_cmp++; if (rbusy_a[0] !== 1'b0) begin n_err++; $display("FAIL sb_wb_rbusy: got %b expected 0", rbusy_a[0]); end
        n_cmp++; if (rdata_a[31:0] !== 32'hCAFE0010) begin n_err++; $display("FAIL sb_wb_rdata: got %h expected cafe0010", rdata_a[31:0]); end
        n_cmp++; if (rbusy_b[0] !== 1'b1) begin n_err++; $display("FAIL sb_wb_nobypass_rbusy: got %b expected 1", rbusy_b[0]); end
        n_cmp++; if (busy_cnt_a !== 6'd1) begin n_err++; $display("FAIL sb_wb_cnt_same: got %0d expected 1", busy_cnt_a); end
        tick();
        wen = 1'b0;
        #1;
        n_cmp++; if (busy_cnt_a !== 6'd0) begin n_err++; $display("FAIL sb_cnt0: got %0d expected 0", busy_cnt_a); end
        n_cmp++; if (rbusy_b[0] !== 1'b0) begin n_err++; $display("FAIL sb_nobypass_cleared: got %b expected 0", rbusy_b[0]); end
    endtask

    task automatic test_collision();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd12;
        tick();
        iss_valid = 1'b1; iss_rd = 5'd12; wen = 1'b1; waddr = 5'd12; wdata = 32'h0BADF00D;
        tick();
        idle(); raddr = {5'd0, 5'd12};
        #1;
        n_cmp++; if (rdata_a[31:0] !== 32'h0BADF00D) begin n_err++; $display("FAIL coll_rdata: got %h expected 0badf00d", rdata_a[31:0]); end
        n_cmp++; if (rbusy_a[0] !== 1'b1) begin n_err++; $display("FAIL coll_rbusy: got %b expected 1", rbusy_a[0]); end
        n_cmp++; if (busy_cnt_a !== 6'd1) begin n_err++; $display("FAIL coll_cnt: got %0d expected 1", busy_cnt_a); end
        wen = 1'b1; waddr = 5'd12; wdata = 32'h0BADF00E;
        tick();
        idle();
        #1;
        n_cmp++; if (busy_cnt_a !== 6'd0) begin n_err++; $display("FAIL coll_retire_cnt: got %0d expected 0", busy_cnt_a); end
    endtask

    task automatic test_flush();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd1; tick();
        iss_rd = 5'd2; tick();
        iss_rd = 5'd4; tick();
        idle(); raddr = {5'd2, 5'd1};
        #1;
        n_cmp++; if (busy_cnt_a !== 6'd3) begin n_err++; $display("FAIL flush_pre_cnt: got %0d expected 3", busy_cnt_a); end
        n_cmp++; if (rbusy_a !== 2'b11) begin n_err++; $display("FAIL flush_pre_rbusy: got %b expected 11", rbusy_a); end
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        idle(); raddr = {5'd9, 5'd4};
        #1;
        n_cmp++; if (busy_cnt_a !== 6'd0) begin n_err++; $display("FAIL flush_cnt: got %0d expected 0", busy_cnt_a); end
        n_cmp++; if (rbusy_a !== 2'b00) begin n_err++; $display("FAIL flush_rbusy: got %b expected 00", rbusy_a); end
    endtask

    task automatic test_multiport();
        idle();
        wen_c = 1'b1; waddr_c = 4'd5; wdata = 32'h00000055; tick();
        waddr_c = 4'd9; wdata = 32'h00000099; iss_valid_c = 1'b1; iss_rd_c = 4'd9; tick();
        iss_valid_c = 1'b0; waddr_c = 4'd14; wdata = 32'h000000EE; tick();
        idle(); raddr_c = {4'd14, 4'd9, 4'd5};
        #1;
        n_cmp++; if (rdata_c[31:0] !== 32'h55) begin n_err++; $display("FAIL mp_p0: got %h expected 55", rdata_c[31:0]); end
        n_cmp++; if (rdata_c[63:32] !== 32'h99) begin n_err++; $display("FAIL mp_p1: got %h expected 99", rdata_c[63:32]); end
        n_cmp++; if (rdata_c[95:64] !== 32'hEE) begin n_err++; $display("FAIL mp_p2: got %h expected ee", rdata_c[95:64]); end
        n_cmp++; if (rbusy_c !== 3'b010) begin n_err++; $display("FAIL mp_rbusy: got %b expected 010", rbusy_c); end
        n_cmp++; if (busy_cnt_c !== 5'd1) begin n_err++; $display("FAIL mp_cnt: got %0d expected 1", busy_cnt_c); end
        raddr_c = {4'd9, 4'd9, 4'd9};
        #1;
        n_cmp++; if (rbusy_c !== 3'b111) begin n_err++; $display("FAIL mp_same_addr: got %b expected 111", rbusy_c); end
        iss_valid_c = 1'b1; iss_rd_c = 4'd15; tick();
        idle(); raddr_c = {4'd15, 4'd0, 4'd9};
        #1;
        n_cmp++; if (busy_cnt_c !== 5'd2) begin n_err++; $display("FAIL mp_cnt2: got %0d expected 2", busy_cnt_c); end
        n_cmp++; if (rbusy_c !== 3'b101) begin n_err++; $display("FAIL mp_rbusy15: got %b expected 101", rbusy_c); end
        flush_c = 1'b1; tick();
        flush_c = 1'b0;
        #1;
        n_cmp++; if (busy_cnt_c !== 5'd0) begin n_err++; $display("FAIL mp_flush_cnt: got %0d expected 0", busy_cnt_c); end
        n_cmp++; if (rbusy_c !== 3'b000) begin n_err++; $display("FAIL mp_flush_rbusy: got %b expected 000", rbusy_c); end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_flush();
        test_multiport();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
